// File: rtl/register_file_pkg.sv
// Shared encodings for the per-thread register file: core pipeline states,
// write-source select values and the special register indices.
package register_file_pkg;

    localparam int DATA_BITS = 8;
    localparam int NUM_REGS  = 16;

    localparam logic [2:0] STATE_IDLE    = 3'b000;
    localparam logic [2:0] STATE_FETCH   = 3'b001;
    localparam logic [2:0] STATE_DECODE  = 3'b010;
    localparam logic [2:0] STATE_REQUEST = 3'b011;
    localparam logic [2:0] STATE_WAIT    = 3'b100;
    localparam logic [2:0] STATE_EXECUTE = 3'b101;
    localparam logic [2:0] STATE_UPDATE  = 3'b110;
    localparam logic [2:0] STATE_DONE    = 3'b111;

    localparam logic [1:0] MUX_ALU      = 2'b00;
    localparam logic [1:0] MUX_LSU      = 2'b01;
    localparam logic [1:0] MUX_IMM      = 2'b10;
    localparam logic [1:0] MUX_RESERVED = 2'b11;

    localparam logic [3:0] BLOCK_IDX  = 4'd13;
    localparam logic [3:0] BLOCK_DIM  = 4'd14;
    localparam logic [3:0] THREAD_IDX = 4'd15;

endpackage

// File: rtl/register_file_if.sv
// Decoded-instruction, datapath and operand bus between the core and a
// thread's register file.
interface register_file_if #(
    parameter int DATA_BITS = register_file_pkg::DATA_BITS
);

    logic                 enable;
    logic [7:0]           block_id;
    logic [2:0]           core_state;
    logic [3:0]           decoded_rd_address;
    logic [3:0]           decoded_rs_address;
    logic [3:0]           decoded_rt_address;
    logic                 decoded_reg_write_enable;
    logic [1:0]           decoded_reg_input_mux;
    logic [DATA_BITS-1:0] decoded_immediate;
    logic [DATA_BITS-1:0] alu_out;
    logic [DATA_BITS-1:0] lsu_out;
    logic [DATA_BITS-1:0] rs;
    logic [DATA_BITS-1:0] rt;

    modport master (
        output enable, block_id, core_state,
        output decoded_rd_address, decoded_rs_address, decoded_rt_address,
        output decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
        output alu_out, lsu_out,
        input  rs, rt
    );

    modport slave (
        input  enable, block_id, core_state,
        input  decoded_rd_address, decoded_rs_address, decoded_rt_address,
        input  decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
        input  alu_out, lsu_out,
        output rs, rt
    );

endinterface

// File: rtl/register_file.sv
// Per-thread 16-entry register file: R0-R12 general purpose, R13-R15 hold
// blockIdx, blockDim and threadIdx. Operands are latched in REQUEST.
module register_file #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = register_file_pkg::DATA_BITS
) (
    input logic            clk,
    input logic            reset,
    register_file_if.slave bus
);

    import register_file_pkg::*;

    logic [DATA_BITS-1:0] regs [NUM_REGS];
    logic [DATA_BITS-1:0] write_data;
    logic                 write_valid;

    // The reserved select value never produces a write.
    always_comb begin
        write_data  = '0;
        write_valid = 1'b1;
        case (bus.decoded_reg_input_mux)
            MUX_ALU: write_data = bus.alu_out;
            MUX_LSU: write_data = bus.lsu_out;
            MUX_IMM: write_data = bus.decoded_immediate;
            default: write_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= 13; i++) begin
                regs[i] <= '0;
            end
            regs[BLOCK_DIM]  <= DATA_BITS'(THREADS_PER_BLOCK);
            regs[THREAD_IDX] <= DATA_BITS'(THREAD_ID);
            bus.rs           <= '0;
            bus.rt           <= '0;
        end else if (bus.enable) begin
            regs[BLOCK_IDX] <= DATA_BITS'(bus.block_id);
            if (bus.core_state == STATE_REQUEST) begin
                bus.rs <= regs[bus.decoded_rs_address];
                bus.rt <= regs[bus.decoded_rt_address];
            end
            // R13-R15 are read-only to instructions; such writes are dropped.
            if (bus.core_state == STATE_UPDATE && bus.decoded_reg_write_enable &&
                write_valid && bus.decoded_rd_address < BLOCK_IDX) begin
                regs[bus.decoded_rd_address] <= write_data;
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed checks of register_file against an array-based
// reference model of the sixteen registers and the two operand latches.
module tb_register_file;

    localparam int TPB = 4;
    localparam int TID = 2;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    logic [7:0] m_regs [16];
    logic [7:0] m_rs;
    logic [7:0] m_rt;

    register_file_if #(.DATA_BITS(8)) bus ();

    register_file #(
        .THREADS_PER_BLOCK(TPB),
        .THREAD_ID(TID),
        .DATA_BITS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_regs[14] = 8'(TPB);
        m_regs[15] = 8'(TID);
        m_rs = 8'h00;
        m_rt = 8'h00;
    endtask

    // Reference behaviour for one rising edge, evaluated from the inputs driven.
    task automatic model_edge();
        logic [7:0] src;
        logic       do_write;
        if (bus.enable) begin
            if (bus.core_state == 3'd3) begin
                m_rs = m_regs[bus.decoded_rs_address];
                m_rt = m_regs[bus.decoded_rt_address];
            end
            do_write = (bus.core_state == 3'd6) && bus.decoded_reg_write_enable &&
                       (bus.decoded_rd_address <= 4'd12);
            src = 8'h00;
            case (bus.decoded_reg_input_mux)
                2'd0: src = bus.alu_out;
                2'd1: src = bus.lsu_out;
                2'd2: src = bus.decoded_immediate;
                default: do_write = 1'b0;
            endcase
            if (do_write) m_regs[bus.decoded_rd_address] = src;
            m_regs[13] = bus.block_id;
        end
    endtask

    task automatic set_inputs(input logic en, input logic [7:0] bid, input logic [2:0] st,
                              input logic [3:0] rd, input logic [3:0] rsa, input logic [3:0] rta,
                              input logic we, input logic [1:0] mux, input logic [7:0] imm,
                              input logic [7:0] alu, input logic [7:0] lsu);
        bus.enable                   = en;
        bus.block_id                 = bid;
        bus.core_state               = st;
        bus.decoded_rd_address       = rd;
        bus.decoded_rs_address       = rsa;
        bus.decoded_rt_address       = rta;
        bus.decoded_reg_write_enable = we;
        bus.decoded_reg_input_mux    = mux;
        bus.decoded_immediate        = imm;
        bus.alu_out                  = alu;
        bus.lsu_out                  = lsu;
    endtask

    // One clock edge with the current inputs, then compare operands to the model.
    task automatic applyStimulus(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        checkOutput({tag, ".rs"}, bus.rs, m_rs);
        checkOutput({tag, ".rt"}, bus.rt, m_rt);
    endtask

    initial begin
        set_inputs(1'b0, 8'h00, 3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        reset = 1'b0;
        model_reset();
        #1;
        checkOutput("reset.rs", bus.rs, 8'h00);
        checkOutput("reset.rt", bus.rt, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Constants in R14/R15 and zero in a general register after reset.
        set_inputs(1'b1, 8'h00, 3'd3, 4'd0, 4'd14, 4'd15, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        applyStimulus("dim_tid");
        checkOutput("dim_const", bus.rs, 8'd4);
        checkOutput("tid_const", bus.rt, 8'd2);
        for (int r = 0; r <= 12; r++) begin
            set_inputs(1'b1, 8'h00, 3'd3, 4'd0, 4'(r), 4'(12 - r), 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
            applyStimulus("gp_zero");
            checkOutput("gp_zero_const", bus.rs, 8'h00);
        end

        // Immediate write to R3, read on both ports.
        set_inputs(1'b1, 8'h00, 3'd6, 4'd3, 4'd0, 4'd0, 1'b1, 2'd2, 8'h5A, 8'h11, 8'h22);
        applyStimulus("wr_r3");
        set_inputs(1'b1, 8'h00, 3'd3, 4'd0, 4'd3, 4'd3, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        applyStimulus("rd_r3");
        checkOutput("r3_rs", bus.rs, 8'h5A);
        checkOutput("r3_rt", bus.rt, 8'h5A);

        // Writes to R15 and reserved-mux writes are dropped.
        set_inputs(1'b1, 8'h00, 3'd6, 4'd15, 4'd0, 4'd0, 1'b1, 2'd0, 8'h00, 8'h77, 8'h00);
        applyStimulus("wr_r15");
        set_inputs(1'b1, 8'h00, 3'd6, 4'd1, 4'd0, 4'd0, 1'b1, 2'd3, 8'hEE, 8'hEE, 8'hEE);
        applyStimulus("wr_rsvd");
        set_inputs(1'b1, 8'h00, 3'd3, 4'd0, 4'd15, 4'd1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        applyStimulus("rd_r15_r1");
        checkOutput("r15_kept", bus.rs, 8'd2);
        checkOutput("r1_kept", bus.rt, 8'h00);

        // Operand latch holds through UPDATE/EXECUTE until the next REQUEST.
        set_inputs(1'b1, 8'h00, 3'd6, 4'd2, 4'd0, 4'd0, 1'b1, 2'd2, 8'h10, 8'h00, 8'h00);
        applyStimulus("wr_r2");
        set_inputs(1'b1, 8'h00, 3'd3, 4'd0, 4'd2, 4'd0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        applyStimulus("rd_r2");
        checkOutput("latch_first", bus.rs, 8'h10);
        set_inputs(1'b1, 8'h00, 3'd6, 4'd2, 4'd2, 4'd0, 1'b1, 2'd1, 8'h00, 8'h00, 8'h99);
        applyStimulus("upd_r2");
        checkOutput("latch_upd", bus.rs, 8'h10);
        set_inputs(1'b1, 8'h00, 3'd5, 4'd0, 4'd2, 4'd0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        applyStimulus("exec");
        checkOutput("latch_exec", bus.rs, 8'h10);
        set_inputs(1'b1, 8'h00, 3'd3, 4'd0, 4'd2, 4'd0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        applyStimulus("rd_r2_again");
        checkOutput("latch_new", bus.rs, 8'h99);

        // R13 follows block_id only while enabled; disabled REQUEST also holds rs/rt.
        set_inputs(1'b1, 8'h21, 3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        applyStimulus("bid_21");
        set_inputs(1'b0, 8'h07, 3'd3, 4'd0, 4'd13, 4'd14, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        applyStimulus("bid_frozen");
        checkOutput("frozen_rs", bus.rs, 8'h99);
        set_inputs(1'b1, 8'h07, 3'd3, 4'd0, 4'd13, 4'd13, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        applyStimulus("rd_r13_old");
        checkOutput("r13_held", bus.rs, 8'h21);
        applyStimulus("rd_r13_new");
        checkOutput("r13_loaded", bus.rs, 8'h07);

        // Asynchronous reset in UPDATE with a write pending to R5.
        set_inputs(1'b1, 8'h00, 3'd6, 4'd5, 4'd0, 4'd0, 1'b1, 2'd2, 8'h33, 8'h00, 8'h00);
        applyStimulus("wr_r5");
        set_inputs(1'b1, 8'h00, 3'd3, 4'd0, 4'd5, 4'd14, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        applyStimulus("rd_r5");
        checkOutput("r5_before", bus.rs, 8'h33);
        set_inputs(1'b1, 8'h00, 3'd6, 4'd5, 4'd0, 4'd0, 1'b1, 2'd2, 8'h44, 8'h00, 8'h00);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checkOutput("async_rs", bus.rs, 8'h00);
        checkOutput("async_rt", bus.rt, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b1;
        set_inputs(1'b1, 8'h00, 3'd3, 4'd0, 4'd5, 4'd13, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        applyStimulus("rd_r5_after");
        checkOutput("r5_cleared", bus.rs, 8'h00);

        // Random traffic across all states, addresses and select values.
        for (int n = 0; n < 400; n++) begin
            set_inputs(($urandom_range(0, 9) != 0),
                       8'($urandom),
                       3'($urandom_range(0, 7)),
                       4'($urandom),
                       4'($urandom),
                       4'($urandom),
                       1'($urandom),
                       2'($urandom),
                       8'($urandom),
                       8'($urandom),
                       8'($urandom));
            applyStimulus("random");
        end

        // Final sweep reading every register through the model.
        for (int r = 0; r < 16; r++) begin
            set_inputs(1'b1, 8'h5C, 3'd3, 4'd0, 4'(r), 4'(15 - r), 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
            applyStimulus("sweep");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter THREADS_PER_BLOCK, default 4: block size, returned as constant in R14.
REQ-002 Parameter THREAD_ID, default 0: this thread's lane index, returned as constant in R15.
REQ-003 Parameter DATA_BITS, default 8: register and data-bus width.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  thread active; when low, all state holds.
REQ-008 block_id  in  8  index of the block currently dispatched to the core.
REQ-009 core_state  in  3  core pipeline stage (IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111).
REQ-010 decoded_rd_address  in  4  destination register index.
REQ-011 decoded_rs_address  in  4  source register 1 index.
REQ-012 decoded_rt_address  in  4  source register 2 index.
REQ-013 decoded_reg_write_enable  in  1  instruction writes rd.
REQ-014 decoded_reg_input_mux  in  2  write source: 00 ALU, 01 LSU, 10 immediate, 11 reserved.
REQ-015 decoded_immediate  in  DATA_BITS  constant operand.
REQ-016 alu_out  in  DATA_BITS  ALU result or zero-padded NZP flags.
REQ-017 lsu_out  in  DATA_BITS  load data.
REQ-018 rs  out  DATA_BITS  registered source operand 1 to ALU/LSU.
REQ-019 rt  out  DATA_BITS  registered source operand 2 to ALU/LSU.

Function
REQ-020 The block SHALL hold 16 registers: R0-R12 general purpose, R13 blockIdx, R14 blockDim, R15 threadIdx.
REQ-021 When enable=1, R13 SHALL load block_id on every rising edge, in any core_state.
REQ-022 When enable=1 and core_state=REQUEST, rs and rt SHALL load R[rs_address] and R[rt_address] on the rising edge; valid from the next cycle until the next REQUEST.
REQ-023 rs and rt SHALL hold their values in every other state, including EXECUTE, where the ALU samples them.
REQ-024 When enable=1, core_state=UPDATE, decoded_reg_write_enable=1 and rd_address<=12, R[rd] SHALL load the mux-selected source on the rising edge.
REQ-025 Mux=11 SHALL suppress the write; writes to R13-R15 SHALL be silently dropped.
REQ-026 Reads in REQUEST SHALL return the value committed by the preceding UPDATE; no same-cycle bypass is required because read and write states never coincide.
REQ-027 rs_address=rt_address SHALL return identical values on rs and rt.
REQ-028 Data SHALL be stored unmodified at DATA_BITS width, with no sign extension or saturation.
REQ-029 enable=0 SHALL freeze all registers, rs and rt, including R13.

Reset
REQ-030 While reset=0, asynchronously: R0-R13=0, R14=THREADS_PER_BLOCK, R15=THREAD_ID, rs=0, rt=0.
REQ-031 Reset asserted mid-instruction, in any state, SHALL abort any pending write; after release, operation resumes on the first rising edge with reset=1.

Structure
REQ-032 Shared package: core_state encodings, reg_input_mux encodings, register indices (BLOCK_IDX=13, BLOCK_DIM=14, THREAD_IDX=15), DATA_BITS.
REQ-033 Single module with no sub-module; the write-source mux is inline combinational logic.

Verification
REQ-034 Reset with THREAD_ID=2, THREADS_PER_BLOCK=4 -> reading R14/R15 in REQUEST gives rs=4, rt=2; R0-R12 read 0.
REQ-035 UPDATE writes R3 with mux=10, imm=0x5A; next REQUEST with rs=3, rt=3 -> rs=rt=0x5A.
REQ-036 UPDATE writes R15 with mux=00, alu_out=0x77 -> R15 still reads THREAD_ID; mux=11 write to R1 -> R1 unchanged.
REQ-037 rs=0x10 latched in REQUEST; UPDATE overwrites the source register with lsu_out=0x99 -> rs stays 0x10 through EXECUTE and changes to 0x99 only after the next REQUEST.
REQ-038 block_id=7 with enable=0 -> R13 unchanged; with enable=1 -> R13=7 after one edge.
REQ-039 reset pulled low during UPDATE with a write pending to R5 -> R5=0 and rs=rt=0 immediately, with no clock edge required.
